// File: rtl/shift_serializer_if.sv
// Load handshake, bit strobe and status bundle for the parallel-in serial-out transmitter.
interface shift_serializer_if #(
    parameter int WIDTH = 32
);
    localparam int BW = $clog2(WIDTH + 1);

    logic             en;
    logic             syn_reset;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             q_serial;
    logic             busy;
    logic [BW-1:0]    bits_left;
    logic             done;

    modport master (
        output en, syn_reset, load_valid, load_data,
        input  load_ready, q_serial, busy, bits_left, done
    );

    modport slave (
        input  en, syn_reset, load_valid, load_data,
        output load_ready, q_serial, busy, bits_left, done
    );
endinterface

// File: rtl/shift_serializer.sv
// Parallel-in serial-out transmitter, MSB first, one bit per en strobe; first bit visible the cycle after load.
// Backpressure: load_ready is low for the whole frame and words offered meanwhile are dropped, never queued.
module shift_serializer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    shift_serializer_if.slave    bus
);
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bits_q,  bits_d;
    logic             done_q,  done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bits_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bits_q  <= bits_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bits_d  = bits_q;
        done_d  = 1'b0;

        // Abort wins over both a pending load and a strobe, and never raises done.
        if (bus.syn_reset) begin
            state_d = IDLE;
            shreg_d = '0;
            bits_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.load_valid) begin
                        shreg_d = bus.load_data;
                        bits_d  = BW'(WIDTH);
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.en) begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        bits_d  = bits_q - BW'(1);
                        if (bits_q == BW'(1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    shreg_d = '0;
                    bits_d  = '0;
                end
            endcase
        end
    end

    // Output is gated by state so IDLE always drives 0 regardless of register contents.
    assign bus.q_serial   = (state_q == SHIFT) & shreg_q[WIDTH-1];
    assign bus.busy       = (state_q == SHIFT);
    assign bus.load_ready = (state_q == IDLE);
    assign bus.bits_left  = bits_q;
    assign bus.done       = done_q;

    a_done_not_busy: assert property (@(posedge clk) disable iff (!reset) !(bus.done && bus.busy));
    a_bits_idle:     assert property (@(posedge clk) disable iff (!reset) (state_q == IDLE) |-> (bits_q == '0));
endmodule

// File: doc/shift_serializer.md
Name: shift_serializer

Overview:
- Parallel-in, serial-out transmitter; the counterpart of the serial-in shift register used in the core.
- Accepts a WIDTH-bit word through a valid/ready load handshake, then shifts it out MSB-first, one bit per enable strobe.
- When its en is shared with the receiving shift register, the receiver's q equals the loaded word after WIDTH strobes.
- Reports busy, bits remaining and a one-cycle frame-done pulse.

Parameters:
WIDTH, 32, word length in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset; a low level clears all state immediately
syn_reset  input  1  synchronous abort/clear, active-high
en  input  1  bit strobe; one bit is shifted out per rising edge with en=1 in SHIFT
load_valid  input  1  load_data is valid
load_data  input  WIDTH  word to transmit
load_ready  output  1  block can accept a word
q_serial  output  1  serial data out, MSB first
busy  output  1  frame in progress
bits_left  output  $clog2(WIDTH+1)  bits not yet shifted out
done  output  1  one-cycle pulse after the final bit is shifted

Behaviour:
- Reset (reset=0, async): state=IDLE, shift register=0, bits_left=0, q_serial=0, busy=0, done=0, load_ready=1.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1, busy=0, q_serial=0.
  - en is ignored.
  - load_valid=1 at an edge captures load_data, sets bits_left=WIDTH and moves to SHIFT.
- SHIFT:
  - load_ready=0, busy=1, q_serial=shift register[WIDTH-1] (combinational from the register).
  - The first bit (MSB) is on q_serial in the cycle after the load edge.
  - Each edge with en=1: shift left by one, insert 0 at the LSB, decrement bits_left.
  - en=0: hold the register, q_serial and bits_left.
  - Edge with en=1 and bits_left=1: last bit consumed. Go to IDLE, bits_left=0, done=1 for exactly the next cycle.
- Receiver timing: the receiver samples q_serial on the same en edge on which the serializer advances, so there is zero skew between them.
- load_valid outside IDLE is ignored; the word is not queued.
- Earliest next load is the cycle after the final-bit edge, when load_ready=1 again. Minimum frame period is WIDTH+1 cycles with en held high.
- syn_reset=1 at an edge, with priority over load and en:
  - state=IDLE, register=0, bits_left=0.
  - No done pulse.
  - A simultaneous load_valid is not accepted.
- Async reset mid-frame: immediate return to the reset values; the partial frame is discarded.
- done clears on the next edge unconditionally. done and busy are never both 1.

Test Plan:
- Load 0xA5A50F0F, en=1 continuously, serializer looped back into a WIDTH=32 shift register with shared en -> q_serial sequence 1,0,1,0,0,1,0,1,...; done high in cycle 33 after load; receiver q=0xA5A50F0F; bits_left counts 32..0.
- Load 0x80000001 with en toggled every third cycle -> bits_left decrements only on en edges; q_serial stable between strobes; done after the 32nd strobe; receiver q=0x80000001.
- Load 0xFFFFFFFF, assert syn_reset after 10 bits -> next cycle busy=0, bits_left=0, q_serial=0, no done; a new load of 0x12345678 then transmits correctly.
- Pull reset low asynchronously mid-frame (between edges) -> outputs reach reset values without waiting for a clock edge; after release, load_ready=1.
- Assert load_valid with 0xDEADBEEF during an active frame, and load_valid together with syn_reset in IDLE -> neither word is accepted; the in-flight frame completes unchanged.
- Two back-to-back frames 0x00000001 then 0x80000000, load_valid held high -> second load accepted in the cycle after the first frame's last-bit edge; the receiver captures both words exactly.
